param_spatial_encoder: RTL and testbench

Next-generation spatial encoder for the HDC pipeline. It binds each channel's item-memory and continuous-item-memory fold (XOR) and bundles across NUM_CHANNEL channels by per-bit majority. It assembles NUM_FOLDS folds into one HV_DIMENSION hypervector and delivers it through a full valid/ready handshake. Relative to the previous encoder it adds:
- channel count, fold width and fold count as parameters;
- thresholded output bits;
- an optional tie-break mode for even channel counts;
- a synchronous flush.

---
 rtl/hdc_pkg.sv | 17 +
 rtl/param_spatial_encoder_bundle_counter.sv | 59 +++++
 rtl/param_spatial_encoder.sv | 138 +++++++++++++
 tb/tb_param_spatial_encoder.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hdc_pkg.sv
// Shared types, tie-mode selectors and width helper for the HDC spatial encoder.
package hdc_pkg;

    typedef enum logic {
        ACCUM  = 1'b0,
        OUTPUT = 1'b1
    } enc_state_e;

    localparam int TIE_ZERO = 0;
    localparam int TIE_CH0  = 1;

    // Bits needed to count from 0 up to and including n.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/param_spatial_encoder_bundle_counter.sv
// One output bit of a fold: counts set bound bits across channels and
// resolves the per-bit majority (with optional channel-0 tie-break).
module bundle_counter
    import hdc_pkg::*;
#(
    parameter int NUM_CHANNEL = 4,
    parameter int TIE_BREAK   = TIE_CH0
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    input  logic en,
    input  logic last,
    input  logic tie_bit,
    output logic majority_out
);

    localparam int CNT_W = cnt_width(NUM_CHANNEL);
    localparam logic [CNT_W:0] N_THRESH = (CNT_W + 1)'(NUM_CHANNEL);
    localparam bit USE_TIE = (TIE_BREAK == TIE_CH0) && ((NUM_CHANNEL % 2) == 0);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] total;
    logic [CNT_W:0]   twice;

    // Fold total including the current beat, and the majority decision on it.
    always_comb begin
        total        = cnt_q + CNT_W'(inc);
        twice        = {total, 1'b0};
        majority_out = 1'b0;
        if (twice > N_THRESH) begin
            majority_out = 1'b1;
        end else if ((twice == N_THRESH) && USE_TIE) begin
            majority_out = tie_bit;
        end
    end

    // Next count: flush clears, an accepted beat accumulates, the last beat restarts.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = last ? '0 : total;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/param_spatial_encoder.sv
// HDC spatial encoder: binds im/cim per channel, bundles channels by per-bit
// majority into folds, and delivers NUM_FOLDS folds as one hypervector.
module param_spatial_encoder
    import hdc_pkg::*;
#(
    parameter int NUM_CHANNEL  = 4,
    parameter int FOLD_WIDTH   = 16,
    parameter int NUM_FOLDS    = 128,
    parameter int HV_DIMENSION = NUM_FOLDS * FOLD_WIDTH,
    parameter int TIE_BREAK    = TIE_CH0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    din_valid,
    output logic                    din_ready,
    input  logic [FOLD_WIDTH-1:0]   im,
    input  logic [FOLD_WIDTH-1:0]   cim,
    output logic                    hvout_valid,
    input  logic                    hvout_ready,
    output logic [HV_DIMENSION-1:0] hvout
);

    if (FOLD_WIDTH < 1) begin : g_bad_fold_width
        $error("param_spatial_encoder: FOLD_WIDTH must be >= 1");
    end
    if (NUM_FOLDS < 1) begin : g_bad_num_folds
        $error("param_spatial_encoder: NUM_FOLDS must be >= 1");
    end
    if (NUM_CHANNEL < 1) begin : g_bad_num_channel
        $error("param_spatial_encoder: NUM_CHANNEL must be >= 1");
    end
    if (HV_DIMENSION != NUM_FOLDS * FOLD_WIDTH) begin : g_bad_hv_dimension
        $error("param_spatial_encoder: HV_DIMENSION must equal NUM_FOLDS*FOLD_WIDTH");
    end

    localparam int CH_W = (NUM_CHANNEL > 1) ? $clog2(NUM_CHANNEL) : 1;
    localparam int FD_W = (NUM_FOLDS > 1) ? $clog2(NUM_FOLDS) : 1;
    localparam logic [CH_W-1:0] LAST_CH   = CH_W'(NUM_CHANNEL - 1);
    localparam logic [FD_W-1:0] LAST_FOLD = FD_W'(NUM_FOLDS - 1);

    enc_state_e              state_q, state_d;
    logic [CH_W-1:0]         chan_cnt_q, chan_cnt_d;
    logic [FD_W-1:0]         fold_cnt_q, fold_cnt_d;
    logic [FOLD_WIDTH-1:0]   tie_q, tie_d;
    logic [HV_DIMENSION-1:0] hvout_q, hvout_d;

    logic [FOLD_WIDTH-1:0]   bound;
    logic [FOLD_WIDTH-1:0]   majority;
    logic                    fire;
    logic                    last_beat;

    assign bound       = im ^ cim;
    assign din_ready   = (state_q == ACCUM);
    assign hvout_valid = (state_q == OUTPUT);
    assign hvout       = hvout_q;
    assign fire        = din_valid && din_ready && !flush;
    assign last_beat   = (chan_cnt_q == LAST_CH);

    for (genvar i = 0; i < FOLD_WIDTH; i++) begin : g_bit
        bundle_counter #(
            .NUM_CHANNEL (NUM_CHANNEL),
            .TIE_BREAK   (TIE_BREAK)
        ) u_bundle_counter (
            .clk          (clk),
            .rst          (rst),
            .clr          (flush),
            .inc          (bound[i]),
            .en           (fire),
            .last         (last_beat),
            .tie_bit      (tie_q[i]),
            .majority_out (majority[i])
        );
    end

    // Next-state: beat accounting, fold write-back, output handshake, flush override.
    always_comb begin
        state_d    = state_q;
        chan_cnt_d = chan_cnt_q;
        fold_cnt_d = fold_cnt_q;
        tie_d      = tie_q;
        hvout_d    = hvout_q;

        case (state_q)
            ACCUM: begin
                if (fire) begin
                    if (last_beat) begin
                        chan_cnt_d = '0;
                        hvout_d[int'(fold_cnt_q) * FOLD_WIDTH +: FOLD_WIDTH] = majority;
                        if (fold_cnt_q == LAST_FOLD) begin
                            fold_cnt_d = '0;
                            state_d    = OUTPUT;
                        end else begin
                            fold_cnt_d = fold_cnt_q + FD_W'(1);
                        end
                    end else begin
                        if (chan_cnt_q == '0) begin
                            tie_d = bound;
                        end
                        chan_cnt_d = chan_cnt_q + CH_W'(1);
                    end
                end
            end
            OUTPUT: begin
                if (hvout_ready) begin
                    state_d = ACCUM;
                end
            end
            default: begin
                state_d = ACCUM;
            end
        endcase

        if (flush) begin
            state_d    = ACCUM;
            chan_cnt_d = '0;
            fold_cnt_d = '0;
        end
    end

    // State, counters, tie register and hypervector register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ACCUM;
            chan_cnt_q <= '0;
            fold_cnt_q <= '0;
            tie_q      <= '0;
            hvout_q    <= '0;
        end else begin
            state_q    <= state_d;
            chan_cnt_q <= chan_cnt_d;
            fold_cnt_q <= fold_cnt_d;
            tie_q      <= tie_d;
            hvout_q    <= hvout_d;
        end
    end

endmodule

// File: tb/tb_param_spatial_encoder.sv
// Scoreboard bench: drivers push model-computed hypervectors, monitors pop on accept.
module tb_param_spatial_encoder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Free-running cycle count for latency measurement.
    always @(posedge clk) cyc <= cyc + 1;

    // DUT A: N=3, W=4, F=2, tie to channel 0
    logic       a_rst, a_flush, a_din_valid, a_din_ready, a_hvout_valid, a_hvout_ready;
    logic [3:0] a_im, a_cim;
    logic [7:0] a_hvout;

    // DUTs B/C: N=4, W=4, F=1, shared inputs, tie-break on (B) and off (C)
    logic       b_rst, b_flush, b_din_valid, b_hvout_ready;
    logic       b_din_ready, c_din_ready, b_hvout_valid, c_hvout_valid;
    logic [3:0] b_im, b_cim, b_hvout, c_hvout;

    param_spatial_encoder #(.NUM_CHANNEL(3), .FOLD_WIDTH(4), .NUM_FOLDS(2), .TIE_BREAK(1)) dut_a (
        .clk(clk), .rst(a_rst), .flush(a_flush), .din_valid(a_din_valid), .din_ready(a_din_ready),
        .im(a_im), .cim(a_cim), .hvout_valid(a_hvout_valid), .hvout_ready(a_hvout_ready), .hvout(a_hvout)
    );

    param_spatial_encoder #(.NUM_CHANNEL(4), .FOLD_WIDTH(4), .NUM_FOLDS(1), .TIE_BREAK(1)) dut_b (
        .clk(clk), .rst(b_rst), .flush(b_flush), .din_valid(b_din_valid), .din_ready(b_din_ready),
        .im(b_im), .cim(b_cim), .hvout_valid(b_hvout_valid), .hvout_ready(b_hvout_ready), .hvout(b_hvout)
    );

    param_spatial_encoder #(.NUM_CHANNEL(4), .FOLD_WIDTH(4), .NUM_FOLDS(1), .TIE_BREAK(0)) dut_c (
        .clk(clk), .rst(b_rst), .flush(b_flush), .din_valid(b_din_valid), .din_ready(c_din_ready),
        .im(b_im), .cim(b_cim), .hvout_valid(c_hvout_valid), .hvout_ready(b_hvout_ready), .hvout(c_hvout)
    );

    logic [3:0] beatsA[$];
    logic [3:0] beatsB[$];
    logic [7:0] expA[$];
    logic [7:0] expB[$];
    logic [7:0] expC[$];

    bit         randReady     = 1'b0;
    int         aValidCycles  = 0;
    int         aFirstValidCyc = -1;
    int         lastFireCyc   = 0;
    logic [7:0] lastPopA = '0;
    logic [7:0] lastPopB = '0;
    logic [7:0] lastPopC = '0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Reference: per fold and bit, count ones across channels and take the majority.
    function automatic logic [7:0] encodeHv(input int n, input int f, input int tieMode,
                                            input logic [3:0] beats[$]);
        logic [7:0] hv;
        hv = '0;
        for (int fold = 0; fold < f; fold++) begin
            for (int b = 0; b < 4; b++) begin
                int ones;
                ones = 0;
                for (int ch = 0; ch < n; ch++) ones += int'(beats[fold * n + ch][b]);
                if (2 * ones > n) hv[fold * 4 + b] = 1'b1;
                else if (2 * ones == n && tieMode == 1) hv[fold * 4 + b] = beats[fold * n][b];
            end
        end
        return hv;
    endfunction

    // Monitor for DUT A: pops an expected vector on every accepted output.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (a_rst && a_hvout_valid) begin
                aValidCycles++;
                if (aFirstValidCyc < 0) aFirstValidCyc = cyc;
                checkOutput("a_din_ready_low_while_valid", 32'(a_din_ready), 32'd0);
                if (a_hvout_ready) begin
                    if (expA.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL a_unexpected_valid: got hvout %0h, expected no output", a_hvout);
                    end else begin
                        lastPopA = expA.pop_front();
                        checkOutput("a_hvout", 32'(a_hvout), 32'(lastPopA));
                    end
                end
            end
        end
    end

    // Monitor for DUTs B and C.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (b_rst && b_hvout_valid && b_hvout_ready) begin
                if (expB.size() == 0) begin
                    checks++; errors++;
                    $display("[TB] FAIL b_unexpected_valid: got hvout %0h, expected no output", b_hvout);
                end else begin
                    lastPopB = expB.pop_front();
                    checkOutput("b_hvout", 32'(b_hvout), 32'(lastPopB));
                end
            end
            if (b_rst && c_hvout_valid && b_hvout_ready) begin
                if (expC.size() == 0) begin
                    checks++; errors++;
                    $display("[TB] FAIL c_unexpected_valid: got hvout %0h, expected no output", c_hvout);
                end else begin
                    lastPopC = expC.pop_front();
                    checkOutput("c_hvout", 32'(c_hvout), 32'(lastPopC));
                end
            end
        end
    end

    task automatic tickA();
        @(negedge clk);
        if (randReady) a_hvout_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic idleA(input int n);
        a_din_valid = 1'b0;
        repeat (n) tickA();
    endtask

    // Offer one beat with the given bound value to DUT A after an optional gap.
    task automatic applyStimulusA(input logic [3:0] bnd, input int gap);
        int w;
        a_din_valid = 1'b0;
        repeat (gap) tickA();
        a_im        = 4'($urandom);
        a_cim       = a_im ^ bnd;
        a_din_valid = 1'b1;
        w = 0;
        while (!a_din_ready && w < 100) begin
            tickA();
            w++;
        end
        if (w >= 100) begin
            checks++; errors++;
            $display("[TB] FAIL a_din_ready_timeout: got din_ready 0, expected 1 within 100 cycles");
            a_din_valid = 1'b0;
            return;
        end
        @(posedge clk);
        beatsA.push_back(bnd);
        if (beatsA.size() == 6) begin
            expA.push_back(encodeHv(3, 2, 1, beatsA));
            beatsA.delete();
        end
        @(negedge clk);
        lastFireCyc = cyc;
        a_din_valid = 1'b0;
    endtask

    // Offer one beat to DUTs B and C together.
    task automatic applyStimulusB(input logic [3:0] bnd);
        int w;
        b_im        = 4'($urandom);
        b_cim       = b_im ^ bnd;
        b_din_valid = 1'b1;
        w = 0;
        while (!(b_din_ready && c_din_ready) && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (w >= 100) begin
            checks++; errors++;
            $display("[TB] FAIL b_din_ready_timeout: got din_ready 0, expected 1 within 100 cycles");
            b_din_valid = 1'b0;
            return;
        end
        @(posedge clk);
        beatsB.push_back(bnd);
        if (beatsB.size() == 4) begin
            expB.push_back(encodeHv(4, 1, 1, beatsB));
            expC.push_back(encodeHv(4, 1, 0, beatsB));
            beatsB.delete();
        end
        @(negedge clk);
        b_din_valid = 1'b0;
    endtask

    task automatic sendTest1A(input int minGap, input int maxGap);
        logic [3:0] vec[6];
        vec = '{4'b0011, 4'b0101, 4'b0110, 4'b1111, 4'b1111, 4'b1111};
        for (int i = 0; i < 6; i++) applyStimulusA(vec[i], $urandom_range(minGap, maxGap));
    endtask

    // Watchdog so the run always ends.
    initial begin
        #200000;
        errors++;
        $display("[TB] FAIL watchdog: got no completion, expected finish before 200000 ns");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int vBefore;
        int w;
        logic [3:0] vec2[4];
        logic [3:0] early[4];

        a_rst = 1'b0; a_flush = 1'b0; a_din_valid = 1'b0; a_hvout_ready = 1'b1; a_im = '0; a_cim = '0;
        b_rst = 1'b0; b_flush = 1'b0; b_din_valid = 1'b0; b_hvout_ready = 1'b1; b_im = '0; b_cim = '0;
        repeat (3) @(negedge clk);
        a_rst = 1'b1;
        b_rst = 1'b1;
        @(negedge clk);

        checkOutput("a_reset_valid", 32'(a_hvout_valid), 32'd0);
        checkOutput("a_reset_ready", 32'(a_din_ready), 32'd1);
        checkOutput("a_reset_hvout", 32'(a_hvout), 32'd0);
        checkOutput("b_reset_valid", 32'(b_hvout_valid), 32'd0);
        checkOutput("b_reset_ready", 32'(b_din_ready), 32'd1);
        checkOutput("c_reset_hvout", 32'(c_hvout), 32'd0);

        $display("[TB] basic vector with continuous valid");
        aFirstValidCyc = -1;
        vBefore = aValidCycles;
        sendTest1A(0, 0);
        idleA(4);
        checkOutput("a_test1_value", 32'(lastPopA), 32'hF7);
        checkOutput("a_test1_pulse_count", 32'(aValidCycles - vBefore), 32'd1);
        checkOutput("a_test1_latency", 32'(aFirstValidCyc - lastFireCyc), 32'd0);

        $display("[TB] stalled input");
        vBefore = aValidCycles;
        sendTest1A(1, 3);
        idleA(4);
        checkOutput("a_stall_value", 32'(lastPopA), 32'hF7);
        checkOutput("a_stall_pulse_count", 32'(aValidCycles - vBefore), 32'd1);

        $display("[TB] output backpressure");
        a_hvout_ready = 1'b0;
        sendTest1A(0, 0);
        a_im = 4'($urandom); a_cim = 4'($urandom); a_din_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            checkOutput("a_bp_valid", 32'(a_hvout_valid), 32'd1);
            checkOutput("a_bp_din_ready", 32'(a_din_ready), 32'd0);
            checkOutput("a_bp_hvout", 32'(a_hvout), 32'hF7);
            @(negedge clk);
        end
        a_hvout_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        a_din_valid = 1'b0;
        checkOutput("a_bp_valid_after_accept", 32'(a_hvout_valid), 32'd0);
        checkOutput("a_bp_din_ready_after_accept", 32'(a_din_ready), 32'd1);
        checkOutput("a_bp_value", 32'(lastPopA), 32'hF7);

        $display("[TB] asynchronous reset mid fold 1");
        early = '{4'b0011, 4'b0101, 4'b0110, 4'b1111};
        for (int i = 0; i < 4; i++) applyStimulusA(early[i], 0);
        checkOutput("a_hvout_before_rst", 32'(a_hvout), 32'hF7);
        #3;
        a_rst = 1'b0;
        #1;
        checkOutput("a_async_rst_valid", 32'(a_hvout_valid), 32'd0);
        checkOutput("a_async_rst_hvout", 32'(a_hvout), 32'd0);
        beatsA.delete();
        repeat (2) @(negedge clk);
        a_rst = 1'b1;
        @(negedge clk);
        sendTest1A(0, 0);
        idleA(3);
        checkOutput("a_after_rst_value", 32'(lastPopA), 32'hF7);

        $display("[TB] flush with the 4th beat");
        for (int i = 0; i < 3; i++) applyStimulusA(early[i], 0);
        a_im = 4'($urandom); a_cim = a_im ^ 4'b1111;
        a_din_valid = 1'b1;
        a_flush = 1'b1;
        checkOutput("a_ready_at_flush", 32'(a_din_ready), 32'd1);
        @(posedge clk);
        beatsA.delete();
        @(negedge clk);
        a_flush = 1'b0;
        a_din_valid = 1'b0;
        vBefore = aValidCycles;
        idleA(4);
        checkOutput("a_no_valid_after_flush", 32'(aValidCycles - vBefore), 32'd0);
        for (int i = 0; i < 6; i++) applyStimulusA(4'b0000, 0);
        idleA(3);
        checkOutput("a_after_flush_value", 32'(lastPopA), 32'h00);

        $display("[TB] random vectors with random gaps and backpressure");
        randReady = 1'b1;
        for (int v = 0; v < 15; v++) begin
            for (int i = 0; i < 6; i++) applyStimulusA(4'($urandom), $urandom_range(0, 2));
        end
        randReady = 1'b0;
        a_hvout_ready = 1'b1;
        w = 0;
        while (expA.size() > 0 && w < 50) begin
            idleA(1);
            w++;
        end
        idleA(2);

        $display("[TB] tie-break configurations");
        vec2 = '{4'b1010, 4'b0101, 4'b0000, 4'b1111};
        for (int i = 0; i < 4; i++) applyStimulusB(vec2[i]);
        repeat (3) @(negedge clk);
        checkOutput("b_tie_ch0_value", 32'(lastPopB), 32'h0A);
        checkOutput("c_tie_zero_value", 32'(lastPopC), 32'h00);
        for (int v = 0; v < 12; v++) begin
            for (int i = 0; i < 4; i++) applyStimulusB(4'($urandom));
        end
        repeat (5) @(negedge clk);

        checkOutput("a_pending_outputs", 32'(expA.size()), 32'd0);
        checkOutput("b_pending_outputs", 32'(expB.size()), 32'd0);
        checkOutput("c_pending_outputs", 32'(expC.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
